// File: rtl/temporal_ngram_encoder_pkg.sv
// Shared defaults and helpers for the temporal N-gram encoder.
// Defaults stand in for the legacy const.vh values HV_DIMENSION and NGRAM_SIZE.
package temporal_ngram_encoder_pkg;

    localparam int unsigned DEF_HV_DIMENSION = 32;
    localparam int unsigned DEF_NGRAM_SIZE   = 3;

    function automatic int unsigned ceilLog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/temporal_ngram_encoder_lane.sv
// ngram_lane: per-modality sample buffer plus the rotate-and-XOR binding tree.
// Output is combinational from the buffer and the incoming sample.
module ngram_lane
    import temporal_ngram_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = DEF_HV_DIMENSION,
    parameter int unsigned NGRAM_SIZE   = DEF_NGRAM_SIZE
) (
    input  logic                    Clk_CI,
    input  logic                    ShiftEn_SI,
    input  logic                    Clear_SI,
    input  logic [0:HV_DIMENSION-1] Sample_DI,
    output logic [0:HV_DIMENSION-1] Ngram_DO
);

    // Bit k moves to k+1, the last bit wraps to index 0.
    function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] x);
        return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
    endfunction

    if (NGRAM_SIZE > 1) begin : gen_buffer
        // SampleBuf[0] is the newest stored sample, SampleBuf[NGRAM_SIZE-2] the oldest.
        logic [0:HV_DIMENSION-1] SampleBuf_DP [NGRAM_SIZE-1];
        logic [0:HV_DIMENSION-1] Acc_D;

        always_ff @(posedge Clk_CI) begin
            if (Clear_SI) begin
                for (int unsigned i = 0; i < NGRAM_SIZE - 1; i++) begin
                    SampleBuf_DP[i] <= '0;
                end
            end else if (ShiftEn_SI) begin
                SampleBuf_DP[0] <= Sample_DI;
                for (int unsigned i = 1; i < NGRAM_SIZE - 1; i++) begin
                    SampleBuf_DP[i] <= SampleBuf_DP[i-1];
                end
            end
        end

        // Horner-style fold: oldest sample accumulates the most rotations.
        always_comb begin
            Acc_D = SampleBuf_DP[NGRAM_SIZE-2];
            for (int unsigned i = 1; i < NGRAM_SIZE - 1; i++) begin
                Acc_D = rho(Acc_D) ^ SampleBuf_DP[NGRAM_SIZE-2-i];
            end
            Ngram_DO = rho(Acc_D) ^ Sample_DI;
        end
    end else begin : gen_passthrough
        assign Ngram_DO = Sample_DI;
    end

endmodule

// File: rtl/temporal_ngram_encoder.sv
// temporal_ngram_encoder: N-gram temporal binding for three modalities with a valid/ready output.
// Define NGRAM_SLIDING_EN for sliding windows; default build emits non-overlapping windows.
module temporal_ngram_encoder
    import temporal_ngram_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = DEF_HV_DIMENSION,
    parameter int unsigned NGRAM_SIZE   = DEF_NGRAM_SIZE
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_mod1_DI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_mod2_DI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_mod3_DI,
    input  logic                    Clear_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] NgramOut_mod1_DO,
    output logic [0:HV_DIMENSION-1] NgramOut_mod2_DO,
    output logic [0:HV_DIMENSION-1] NgramOut_mod3_DO
);

    localparam int unsigned CNTR_WIDTH = ceilLog2(NGRAM_SIZE + 1);
    localparam logic [CNTR_WIDTH-1:0] FILL_FULL = CNTR_WIDTH'(NGRAM_SIZE);

    localparam logic ACCEPT        = 1'b0;
    localparam logic OUTPUT_STABLE = 1'b1;

    logic                    State_SP;
    logic [CNTR_WIDTH-1:0]   FillCntr_SP;
    logic [CNTR_WIDTH-1:0]   FillInc_S;
    logic [CNTR_WIDTH-1:0]   FillAfterOutput_S;
    logic                    Accept_S;
    logic                    Complete_S;
    logic                    LaneClear_S;
    logic [0:HV_DIMENSION-1] Ngram1_D, Ngram2_D, Ngram3_D;

    assign ReadyOut_SO = (State_SP == ACCEPT);
    assign ValidOut_SO = (State_SP == OUTPUT_STABLE);

    always_comb begin
        Accept_S   = (State_SP == ACCEPT) && ValidIn_SI;
        FillInc_S  = (FillCntr_SP == FILL_FULL) ? FILL_FULL : FillCntr_SP + 1'b1;
        Complete_S = Accept_S && !Clear_SI && (FillInc_S == FILL_FULL);
`ifdef NGRAM_SLIDING_EN
        FillAfterOutput_S = FILL_FULL;
        LaneClear_S       = Reset_RI || Clear_SI;
`else
        // Completion empties the window so the next N-gram shares no samples.
        FillAfterOutput_S = '0;
        LaneClear_S       = Reset_RI || Clear_SI || Complete_S;
`endif
    end

    ngram_lane #(.HV_DIMENSION(HV_DIMENSION), .NGRAM_SIZE(NGRAM_SIZE)) u_lane1 (
        .Clk_CI     (Clk_CI),
        .ShiftEn_SI (Accept_S),
        .Clear_SI   (LaneClear_S),
        .Sample_DI  (HypervectorIn_mod1_DI),
        .Ngram_DO   (Ngram1_D)
    );

    ngram_lane #(.HV_DIMENSION(HV_DIMENSION), .NGRAM_SIZE(NGRAM_SIZE)) u_lane2 (
        .Clk_CI     (Clk_CI),
        .ShiftEn_SI (Accept_S),
        .Clear_SI   (LaneClear_S),
        .Sample_DI  (HypervectorIn_mod2_DI),
        .Ngram_DO   (Ngram2_D)
    );

    ngram_lane #(.HV_DIMENSION(HV_DIMENSION), .NGRAM_SIZE(NGRAM_SIZE)) u_lane3 (
        .Clk_CI     (Clk_CI),
        .ShiftEn_SI (Accept_S),
        .Clear_SI   (LaneClear_S),
        .Sample_DI  (HypervectorIn_mod3_DI),
        .Ngram_DO   (Ngram3_D)
    );

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            State_SP         <= ACCEPT;
            FillCntr_SP      <= '0;
            NgramOut_mod1_DO <= '0;
            NgramOut_mod2_DO <= '0;
            NgramOut_mod3_DO <= '0;
        end else begin
            case (State_SP)
                ACCEPT: begin
                    if (Clear_SI) begin
                        FillCntr_SP <= '0;
                    end else if (Complete_S) begin
                        NgramOut_mod1_DO <= Ngram1_D;
                        NgramOut_mod2_DO <= Ngram2_D;
                        NgramOut_mod3_DO <= Ngram3_D;
                        FillCntr_SP      <= FillAfterOutput_S;
                        State_SP         <= OUTPUT_STABLE;
                    end else if (Accept_S) begin
                        FillCntr_SP <= FillInc_S;
                    end
                end
                default: begin
                    if (Clear_SI) begin
                        FillCntr_SP <= '0;
                    end
                    if (ReadyIn_SI) begin
                        State_SP <= ACCEPT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Directed bench for temporal_ngram_encoder (NGRAM_SIZE=3, 32-bit hypervectors).
// Expected counts for the streaming sequence follow NGRAM_SLIDING_EN.
module tb_temporal_ngram_encoder;

    localparam int unsigned D = 32;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         ValidIn = 1'b0;
    logic         ReadyOut;
    logic [0:D-1] In1 = '0, In2 = '0, In3 = '0;
    logic         Clear = 1'b0;
    logic         ValidOut;
    logic         ReadyIn = 1'b0;
    logic [0:D-1] Out1, Out2, Out3;

    int checks = 0;
    int passed = 0;

    temporal_ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(3)) dut (
        .Clk_CI                (Clk),
        .Reset_RI              (Reset),
        .ValidIn_SI            (ValidIn),
        .ReadyOut_SO           (ReadyOut),
        .HypervectorIn_mod1_DI (In1),
        .HypervectorIn_mod2_DI (In2),
        .HypervectorIn_mod3_DI (In3),
        .Clear_SI              (Clear),
        .ValidOut_SO           (ValidOut),
        .ReadyIn_SI            (ReadyIn),
        .NgramOut_mod1_DO      (Out1),
        .NgramOut_mod2_DO      (Out2),
        .NgramOut_mod3_DO      (Out3)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic         valid, clear, rdy;
        logic [0:D-1] in1, in2, in3;
        logic         expVo, expRo;
        logic [0:D-1] e1, e2, e3;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [0:D-1] b(input int unsigned k);
        logic [0:D-1] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic av(input logic v, input logic c, input logic r,
                      input logic [0:D-1] i1, input logic [0:D-1] i2, input logic [0:D-1] i3,
                      input logic vo, input logic ro,
                      input logic [0:D-1] e1, input logic [0:D-1] e2, input logic [0:D-1] e3);
        vec_t t;
        t.valid = v; t.clear = c; t.rdy = r;
        t.in1 = i1; t.in2 = i2; t.in3 = i3;
        t.expVo = vo; t.expRo = ro;
        t.e1 = e1; t.e2 = e2; t.e3 = e3;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [D-1:0] act, input logic [D-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic c, input logic r,
                         input logic [0:D-1] i1, input logic [0:D-1] i2, input logic [0:D-1] i3);
        ValidIn = v; Clear = c; ReadyIn = r;
        In1 = i1; In2 = i2; In3 = i3;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [0:D-1] Z, ones, W1, W2, C1, C3, M2;
        int outCount, expCount, nAcc;
        logic [0:D-1] lastOut;
        Z = '0;
        ones = '1;
        W1 = b(31) | b(0) | b(1);
        W2 = b(12) | b(21) | b(30);
        C1 = b(0) | b(1) | b(2);
        C3 = b(18) | b(1) | b(0);
        M2 = b(3) | b(2) | b(1);

        // idle after reset, then first N-gram with mod3 cancelling to zero
        av(0,0,0, Z,Z,Z,             0,1, Z,Z,Z);
        av(1,0,0, b(0),b(5),b(31),   0,1, Z,Z,Z);
        av(1,0,0, Z,b(5),Z,          0,1, Z,Z,Z);
        av(1,0,0, Z,b(7),b(1),       1,0, b(2),b(6),Z);
        av(1,0,1, ones,ones,ones,    0,1, b(2),b(6),Z);
        av(0,1,0, Z,Z,Z,             0,1, b(2),b(6),Z);
        // wrap-around across the top bit
        av(1,0,0, b(31),b(10),ones,  0,1, b(2),b(6),Z);
        av(1,0,0, b(31),b(20),ones,  0,1, b(2),b(6),Z);
        av(1,0,0, b(31),b(30),ones,  1,0, W1,W2,ones);
        // downstream stalls for five cycles
        for (int i = 0; i < 5; i++) av(1,0,0, ones,ones,ones, 1,0, W1,W2,ones);
        av(0,0,1, Z,Z,Z,             0,1, W1,W2,ones);
        // clear after two accepts, clear beating a same-cycle sample
        av(0,1,0, Z,Z,Z,             0,1, W1,W2,ones);
        av(1,0,0, b(3),Z,Z,          0,1, W1,W2,ones);
        av(1,0,0, b(4),Z,Z,          0,1, W1,W2,ones);
        av(1,1,0, b(9),b(9),b(9),    0,1, W1,W2,ones);
        av(1,0,0, b(0),Z,b(16),      0,1, W1,W2,ones);
        av(1,0,0, b(0),Z,b(0),       0,1, W1,W2,ones);
        av(1,0,0, b(0),Z,b(0),       1,0, C1,Z,C3);
        av(0,0,1, Z,Z,Z,             0,1, C1,Z,C3);
        // clear while an output is pending keeps the output
        av(0,1,0, Z,Z,Z,             0,1, C1,Z,C3);
        av(1,0,0, b(5),b(1),Z,       0,1, C1,Z,C3);
        av(1,0,0, b(6),b(1),Z,       0,1, C1,Z,C3);
        av(1,0,0, b(7),b(1),Z,       1,0, b(7),M2,Z);
        av(0,1,0, Z,Z,Z,             1,0, b(7),M2,Z);
        av(0,0,1, Z,Z,Z,             0,1, b(7),M2,Z);
        av(1,0,0, b(8),Z,Z,          0,1, b(7),M2,Z);
        av(1,0,0, Z,b(4),Z,          0,1, b(7),M2,Z);
        av(1,0,0, Z,Z,b(20),         1,0, b(10),b(5),b(20));
        av(0,0,1, Z,Z,Z,             0,1, b(10),b(5),b(20));

        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.vo", ValidOut, 0);
        chk("rst.ro", ReadyOut, 1);
        chk("rst.out1", Out1, Z);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].clear, vecs[i].rdy, vecs[i].in1, vecs[i].in2, vecs[i].in3);
            chk($sformatf("vec%0d.vo", i), ValidOut, vecs[i].expVo);
            chk($sformatf("vec%0d.ro", i), ReadyOut, vecs[i].expRo);
            chk($sformatf("vec%0d.out1", i), Out1, vecs[i].e1);
            chk($sformatf("vec%0d.out2", i), Out2, vecs[i].e2);
            chk($sformatf("vec%0d.out3", i), Out3, vecs[i].e3);
        end

        // streaming: every accept immediately drained
`ifdef NGRAM_SLIDING_EN
        nAcc = 5; expCount = 3;
`else
        nAcc = 6; expCount = 2;
`endif
        outCount = 0;
        lastOut = Z;
        drive(0,1,0, Z,Z,Z);
        for (int i = 0; i < nAcc; i++) begin
            drive(1,0,0, b(0),Z,Z);
            if (ValidOut) begin
                outCount++;
                lastOut = Out1;
                drive(0,0,1, Z,Z,Z);
            end
        end
        chk("stream.count", outCount, expCount);
        chk("stream.value", lastOut, C1);

        // reset while an output is pending, then a fresh fill is needed
        drive(0,1,0, Z,Z,Z);
        for (int i = 0; i < 3; i++) drive(1,0,0, b(3),b(3),b(3));
        chk("pre.vo", ValidOut, 1);
        Reset = 1'b1;
        drive(0,0,0, Z,Z,Z);
        Reset = 1'b0;
        chk("midrst.vo", ValidOut, 0);
        chk("midrst.ro", ReadyOut, 1);
        chk("midrst.out1", Out1, Z);
        chk("midrst.out2", Out2, Z);
        drive(1,0,0, b(0),Z,Z);
        drive(1,0,0, Z,Z,Z);
        chk("refill.vo2", ValidOut, 0);
        drive(1,0,0, Z,Z,Z);
        chk("refill.vo3", ValidOut, 1);
        chk("refill.out1", Out1, b(2));
        chk("refill.out2", Out2, Z);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
